// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first bit-serial WIDTH-bit adder built around one
// full-adder cell and a registered carry. Operands arrive on a valid/ready
// handshake; {c_out, sum} leaves on a second valid/ready handshake.
// Optional feature: define SERIAL_SUB_EN to add a `sub` input that turns
// the operation into a - b (c_out = 1 means no borrow).

// Single-bit full adder used as the only arithmetic cell of the serial adder.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  // Plain combinational sum/carry of three bits.
  always_comb begin
    s_o = a_i ^ b_i ^ c_i;
    c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  end

endmodule

module bit_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  // acc_sr holds the unconsumed bits of A in its low part and the sum bits
  // produced so far in its high part; after WIDTH shifts it is the sum.
  logic [WIDTH-1:0] acc_sr_q, acc_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             in_ready_q, in_ready_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_SUB_EN
  // Subtract mode: a + ~b + 1, so the incoming carry is forced to 1.
  always_comb begin
    b_load = sub ? ~b : b;
    c_load = sub ? 1'b1 : c_in;
  end
`else
  // Add-only build: operands load unchanged.
  always_comb begin
    b_load = b;
    c_load = c_in;
  end
`endif

  full_adder u_fa (
    .a_i (acc_sr_q[0]),
    .b_i (b_sr_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_co)
  );

  assign accept    = in_valid && in_ready_q;
  assign last_bit  = (cnt_q == '0);
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;

  // Next-state logic: sequencing, serial datapath and result capture.
  always_comb begin
    state_d  = state_q;
    acc_sr_d = acc_sr_q;
    b_sr_d   = b_sr_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    c_out_d  = c_out_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_sr_d = a;
          b_sr_d   = b_load;
          carry_d  = c_load;
          cnt_d    = CW'(WIDTH - 1);
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_sr_d = {fa_s, acc_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        carry_d  = fa_co;
        if (last_bit) begin
          sum_d   = {fa_s, acc_sr_q[WIDTH-1:1]};
          c_out_d = fa_co;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_sr_q   <= '0;
      b_sr_q     <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      c_out_q    <= 1'b0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_sr_q   <= acc_sr_d;
      b_sr_q     <= b_sr_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      c_out_q    <= c_out_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder: a driver pushes the arithmetic
// expectation on every accepted operand set, a monitor pops and compares on
// every result handshake. Honours SERIAL_SUB_EN when defined.
module tb_bit_serial_adder;

  localparam int unsigned W = 16;
`ifdef SERIAL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         c_out;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   bp_mode = 1'b0;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef SERIAL_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: plain unsigned arithmetic on the captured operands.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tc, input logic ts, input int acc);
    exp_t       r;
    logic [W:0] t;
    if (SUB_EN && ts) begin
      r.s  = ta - tb;
      r.co = (ta >= tb);
    end else begin
      t    = {1'b0, ta} + {1'b0, tb} + (W+1)'(tc);
      r.s  = t[W-1:0];
      r.co = t[W];
    end
    r.acc = acc;
    return r;
  endfunction

  // Present operands until accepted, record expectation, then scramble inputs.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic ts);
    bit accepted = 1'b0;
    int n = 0;
    @(posedge clk); #1;
    a = ta; b = tb; c_in = tc; sub = ts; in_valid = 1'b1;
    while (!accepted && n < 200) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(ta, tb, tc, ts, cyc + 1));
        accepted = 1'b1;
      end
      n++;
    end
    if (!accepted) fail("accept_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_out_valid(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    if (!out_valid) fail(name);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || out_valid) fail("drain_timeout");
  endtask

  // Random consumer backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_mode) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: latency on each rise of out_valid, data on each result handshake.
  initial begin
    exp_t e;
    bit   prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov) begin
          if (exp_q.size() == 0) fail("unexpected_result");
          else chk("latency", cyc - exp_q[0].acc, W);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            fail("result_without_request");
          end else begin
            e = exp_q.pop_front();
            chk("sum", sum, e.s);
            chk("c_out", c_out, e.co);
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_c_out", c_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_release", in_ready, 1);
    out_ready = 1'b1;

    // Basic add, then ready returns one cycle after the result handshake
    issue(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_out_valid("t2_out_valid_timeout");
    @(negedge clk);
    chk("t2_ready_back", in_ready, 1);
    chk("t2_out_valid_drop", out_valid, 0);

    // Full carry ripple
    issue(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    wait_idle();

    // Backpressure with in_valid pulses while busy
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(16'h8000, 16'h8000, 1'b0, 1'b0);
    in_valid = 1'b1;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        chk("busy_in_ready", in_ready, 0);
        n++;
      end while (!out_valid && n < 100);
      if (!out_valid) fail("t4_out_valid_timeout");
    end
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_sum", sum, 16'h0000);
      chk("bp_c_out", c_out, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    // Reset in the middle of RUN
    issue(16'hABCD, 16'h1357, 1'b1, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_c_out", c_out, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_idle();

`ifdef SERIAL_SUB_EN
    issue(16'h0005, 16'h0007, 1'b0, 1'b1);
    issue(16'h0007, 16'h0005, 1'b0, 1'b1);
    wait_idle();
`endif

    // Random operands under random backpressure
    bp_mode = 1'b1;
    repeat (40) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end
    wait_idle();
    bp_mode = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;

    @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
